// File: rtl/vending_pkg.sv
// Shared types and constants for the vending change-dispense path: FSM states,
// hopper coin-select codes and default denominations.
package vending_pkg;

  localparam int MONEY_W = 5;

  localparam int DEF_DENOM_HI  = 10;
  localparam int DEF_DENOM_MID = 5;
  localparam int DEF_DENOM_LO  = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALC,
    S_WAIT,
    S_CHECK,
    S_SELECT,
    S_REQ,
    S_DONE,
    S_REJECT,
    S_FAIL
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_LO   = 2'd1,
    COIN_MID  = 2'd2,
    COIN_HI   = 2'd3
  } coin_t;

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters: refill to full, decrement on a paid coin,
// or clear a denomination whose hopper channel jammed.
module coin_inventory
  import vending_pkg::*;
#(
  parameter int INV_W      = 8,
  parameter int INIT_COUNT = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_refill,
  input  logic             i_dec,
  input  logic             i_jam,
  input  coin_t            i_sel,
  output logic [INV_W-1:0] o_inv_hi,
  output logic [INV_W-1:0] o_inv_mid,
  output logic [INV_W-1:0] o_inv_lo,
  output logic             o_empty_hi,
  output logic             o_empty_mid,
  output logic             o_empty_lo
);

  localparam logic [INV_W-1:0] FULL = INV_W'(INIT_COUNT);

  logic [INV_W-1:0] r_hi;
  logic [INV_W-1:0] r_mid;
  logic [INV_W-1:0] r_lo;

  // Jam wins over a decrement; counters never wrap below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi  <= FULL;
      r_mid <= FULL;
      r_lo  <= FULL;
    end else if (i_refill) begin
      r_hi  <= FULL;
      r_mid <= FULL;
      r_lo  <= FULL;
    end else if (i_dec || i_jam) begin
      case (i_sel)
        COIN_HI:  r_hi  <= (i_jam || r_hi  == '0) ? '0 : r_hi  - 1'b1;
        COIN_MID: r_mid <= (i_jam || r_mid == '0) ? '0 : r_mid - 1'b1;
        COIN_LO:  r_lo  <= (i_jam || r_lo  == '0) ? '0 : r_lo  - 1'b1;
        default:  ;
      endcase
    end
  end

  assign o_inv_hi    = r_hi;
  assign o_inv_mid   = r_mid;
  assign o_inv_lo    = r_lo;
  assign o_empty_hi  = (r_hi  == '0);
  assign o_empty_mid = (r_mid == '0);
  assign o_empty_lo  = (r_lo  == '0);

endmodule

// File: rtl/change_dispense_controller.sv
// Runs one vending transaction: triggers the change calculator, pays change
// greedily via the hopper handshake. COIN_TIMEOUT_EN adds a jammed-coin timeout.
module change_dispense_controller
  import vending_pkg::*;
#(
  parameter int DENOM_HI   = DEF_DENOM_HI,
  parameter int DENOM_MID  = DEF_DENOM_MID,
  parameter int DENOM_LO   = DEF_DENOM_LO,
  parameter int INV_W      = 8,
  parameter int INIT_COUNT = 20
`ifdef COIN_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 64
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MONEY_W-1:0] current_amount,
  input  logic [MONEY_W-1:0] product_price,
  input  logic               refill,
  output logic [MONEY_W-1:0] calc_current,
  output logic [MONEY_W-1:0] calc_price,
  output logic               calculate,
  input  logic [MONEY_W-1:0] change_amount,
  input  logic               valid_transaction,
  output logic               coin_req,
  output logic [1:0]         coin_sel,
  input  logic               coin_ack,
  output logic               busy,
  output logic               done,
  output logic               reject,
  output logic               fail,
  output logic [MONEY_W-1:0] shortfall,
  output logic [INV_W-1:0]   inv_hi,
  output logic [INV_W-1:0]   inv_mid,
  output logic [INV_W-1:0]   inv_lo
);

  localparam logic [MONEY_W-1:0] D_HI  = MONEY_W'(DENOM_HI);
  localparam logic [MONEY_W-1:0] D_MID = MONEY_W'(DENOM_MID);
  localparam logic [MONEY_W-1:0] D_LO  = MONEY_W'(DENOM_LO);

  state_t             r_state;
  logic [MONEY_W-1:0] r_remain;
  logic [MONEY_W-1:0] r_calcCurrent;
  logic [MONEY_W-1:0] r_calcPrice;
  logic [MONEY_W-1:0] r_shortfall;
  logic               r_calculate;
  logic               r_coinReq;
  coin_t              r_coinSel;
  logic               r_busy;
  logic               r_done;
  logic               r_reject;
  logic               r_fail;

  logic [MONEY_W-1:0] w_denom;
  logic               w_refill;
  logic               w_dec;
  logic               w_jam;
  logic               w_emptyHi;
  logic               w_emptyMid;
  logic               w_emptyLo;

`ifdef COIN_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] r_ackCnt;
  logic             w_timeout;
  assign w_timeout = (r_ackCnt == ACK_LAST);
  assign w_jam     = (r_state == S_REQ) && !coin_ack && w_timeout;
`else
  assign w_jam = 1'b0;
`endif

  assign w_refill = refill && (r_state == S_IDLE);
  assign w_dec    = coin_ack && (r_state == S_REQ);

  always_comb begin
    w_denom = '0;
    case (r_coinSel)
      COIN_HI:  w_denom = D_HI;
      COIN_MID: w_denom = D_MID;
      COIN_LO:  w_denom = D_LO;
      default:  w_denom = '0;
    endcase
  end

  coin_inventory #(
    .INV_W      (INV_W),
    .INIT_COUNT (INIT_COUNT)
  ) u_inventory (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_refill    (w_refill),
    .i_dec       (w_dec),
    .i_jam       (w_jam),
    .i_sel       (r_coinSel),
    .o_inv_hi    (inv_hi),
    .o_inv_mid   (inv_mid),
    .o_inv_lo    (inv_lo),
    .o_empty_hi  (w_emptyHi),
    .o_empty_mid (w_emptyMid),
    .o_empty_lo  (w_emptyLo)
  );

  // Transaction sequencer; every output is registered and set on state entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_remain      <= '0;
      r_calcCurrent <= '0;
      r_calcPrice   <= '0;
      r_shortfall   <= '0;
      r_calculate   <= 1'b0;
      r_coinReq     <= 1'b0;
      r_coinSel     <= COIN_NONE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_reject      <= 1'b0;
      r_fail        <= 1'b0;
`ifdef COIN_TIMEOUT_EN
      r_ackCnt      <= '0;
`endif
    end else begin
      r_calculate <= 1'b0;
      r_done      <= 1'b0;
      r_reject    <= 1'b0;
      r_fail      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_calcCurrent <= current_amount;
            r_calcPrice   <= product_price;
            r_shortfall   <= '0;
            r_calculate   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_CALC;
          end
        end
        S_CALC:  r_state <= S_WAIT;
        S_WAIT:  r_state <= S_CHECK;
        S_CHECK: begin
          if (!valid_transaction) begin
            r_reject <= 1'b1;
            r_state  <= S_REJECT;
          end else begin
            r_remain <= change_amount;
            r_state  <= S_SELECT;
          end
        end
        S_SELECT: begin
`ifdef COIN_TIMEOUT_EN
          r_ackCnt <= '0;
`endif
          // Greedy, largest coin first, no backtracking.
          if (r_remain == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_remain >= D_HI && !w_emptyHi) begin
            r_coinSel <= COIN_HI;
            r_coinReq <= 1'b1;
            r_state   <= S_REQ;
          end else if (r_remain >= D_MID && !w_emptyMid) begin
            r_coinSel <= COIN_MID;
            r_coinReq <= 1'b1;
            r_state   <= S_REQ;
          end else if (r_remain >= D_LO && !w_emptyLo) begin
            r_coinSel <= COIN_LO;
            r_coinReq <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_fail      <= 1'b1;
            r_shortfall <= r_remain;
            r_state     <= S_FAIL;
          end
        end
        S_REQ: begin
          if (coin_ack) begin
            r_remain  <= r_remain - w_denom;
            r_coinReq <= 1'b0;
            r_coinSel <= COIN_NONE;
            r_state   <= S_SELECT;
          end
`ifdef COIN_TIMEOUT_EN
          else if (w_timeout) begin
            r_coinReq <= 1'b0;
            r_coinSel <= COIN_NONE;
            r_state   <= S_SELECT;
          end else begin
            r_ackCnt <= r_ackCnt + 1'b1;
          end
`endif
        end
        S_DONE, S_REJECT, S_FAIL: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign calc_current = r_calcCurrent;
  assign calc_price   = r_calcPrice;
  assign calculate    = r_calculate;
  assign coin_req     = r_coinReq;
  assign coin_sel     = r_coinSel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign reject       = r_reject;
  assign fail         = r_fail;
  assign shortfall    = r_shortfall;

endmodule

// File: tb/tb_change_dispense_controller.sv
// Randomised bench for change_dispense_controller: a calculator model and a
// random-latency hopper drive the DUT; outcomes are compared to a greedy payout model.
module tb_change_dispense_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       refill = 1'b0;
  logic       coin_ack = 1'b0;
  logic [4:0] current_amount = '0;
  logic [4:0] product_price = '0;
  logic [4:0] calc_current, calc_price, change_amount, shortfall;
  logic       calculate, valid_transaction, coin_req, busy, done, reject, fail;
  logic [1:0] coin_sel;
  logic [7:0] inv_hi, inv_mid, inv_lo;

  int assertCount = 0;
  int failCount = 0;
  int invHi = 20;
  int invMid = 20;
  int invLo = 20;

  always #5 clk = ~clk;

  change_dispense_controller dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .current_amount    (current_amount),
    .product_price     (product_price),
    .refill            (refill),
    .calc_current      (calc_current),
    .calc_price        (calc_price),
    .calculate         (calculate),
    .change_amount     (change_amount),
    .valid_transaction (valid_transaction),
    .coin_req          (coin_req),
    .coin_sel          (coin_sel),
    .coin_ack          (coin_ack),
    .busy              (busy),
    .done              (done),
    .reject            (reject),
    .fail              (fail),
    .shortfall         (shortfall),
    .inv_hi            (inv_hi),
    .inv_mid           (inv_mid),
    .inv_lo            (inv_lo)
  );

  // Behavioural change calculator with a registered result.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      change_amount     <= '0;
      valid_transaction <= 1'b0;
    end else if (calculate) begin
      valid_transaction <= (calc_current >= calc_price);
      change_amount     <= (calc_current >= calc_price) ? calc_current - calc_price : 5'd0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkInventory(input string tag);
    checkOutput({tag, "_inv_hi"}, 32'(inv_hi), invHi);
    checkOutput({tag, "_inv_mid"}, 32'(inv_mid), invMid);
    checkOutput({tag, "_inv_lo"}, 32'(inv_lo), invLo);
  endtask

  // One full transaction; jamHi makes the hopper ignore every HI request.
  task automatic applyStimulus(input int cur, input int price, input bit withRefill, input bit jamHi);
    int r, nHi, nMid, nLo, expKind, expShort;
    int kind, pulses, lat, calcPulses, delay, gotShort;
    bit ended, prevReq;
    int expQ[$];
    int gotQ[$];

    if (withRefill) begin
      invHi = 20; invMid = 20; invLo = 20;
    end
    if (cur < price) begin
      expKind = 1;
      r = 0;
    end else begin
      expKind = 0;
      r = cur - price;
      if (jamHi && r >= 10 && invHi > 0) begin
        expQ.push_back(3);
        invHi = 0;
      end
      nHi = (r / 10 < invHi) ? r / 10 : invHi;
      r -= 10 * nHi; invHi -= nHi;
      nMid = (r / 5 < invMid) ? r / 5 : invMid;
      r -= 5 * nMid; invMid -= nMid;
      nLo = (r < invLo) ? r : invLo;
      r -= nLo; invLo -= nLo;
      repeat (nHi) expQ.push_back(3);
      repeat (nMid) expQ.push_back(2);
      repeat (nLo) expQ.push_back(1);
      if (r != 0) expKind = 2;
    end
    expShort = (expKind == 2) ? r : 0;

    @(negedge clk);
    start = 1'b1;
    current_amount = 5'(cur);
    product_price = 5'(price);
    refill = withRefill;
    @(negedge clk);
    start = 1'b0;
    refill = 1'b0;

    ended = 0; prevReq = 0; kind = -1; pulses = 0; lat = 0; calcPulses = 0; gotShort = -1;
    delay = $urandom_range(0, 3);
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      calcPulses += int'(calculate);
      if (done || reject || fail) begin
        ended = 1;
        lat = k;
        kind = done ? 0 : (reject ? 1 : 2);
        pulses = int'(done) + int'(reject) + int'(fail);
        gotShort = int'(shortfall);
        break;
      end
      coin_ack = 1'b0;
      start = 1'b0;
      refill = 1'b0;
      if (coin_req) begin
        if (!prevReq) gotQ.push_back(int'(coin_sel));
        if (!(jamHi && coin_sel == 2'd3)) begin
          if (delay == 0) begin
            coin_ack = 1'b1;
            delay = $urandom_range(0, 3);
          end else begin
            delay--;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        coin_ack = 1'b1;
      end
      prevReq = coin_req;
      if (k == 2 || $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        current_amount = 5'($urandom_range(0, 31));
        product_price = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 15) == 0) refill = 1'b1;
    end
    coin_ack = 1'b0;
    start = 1'b0;
    refill = 1'b0;

    checkOutput("txn_ended", 32'(ended), 1);
    checkOutput("outcome", kind, expKind);
    checkOutput("pulse_count", pulses, 1);
    checkOutput("calc_pulses", calcPulses, 1);
    checkOutput("calc_current_held", 32'(calc_current), cur);
    checkOutput("calc_price_held", 32'(calc_price), price);
    checkOutput("shortfall", gotShort, expShort);
    checkOutput("coin_count", gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkOutput("coin_sel", gotQ[i], expQ[i]);
    if (cur <= price)
      checkOutput("latency", lat, (cur < price) ? 4 : 5);
    checkInventory("txn");

    @(negedge clk);
    checkOutput("pulse_drop", 32'(done | reject | fail), 0);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("shortfall_held", 32'(shortfall), expShort);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_coin_req"}, 32'(coin_req), 0);
    checkOutput({tag, "_coin_sel"}, 32'(coin_sel), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_calculate"}, 32'(calculate), 0);
    checkOutput({tag, "_pulses"}, 32'(done | reject | fail), 0);
    checkOutput({tag, "_shortfall"}, 32'(shortfall), 0);
    checkOutput({tag, "_calc_current"}, 32'(calc_current), 0);
    checkOutput({tag, "_calc_price"}, 32'(calc_price), 0);
    checkInventory(tag);
  endtask

  initial begin
    bit seen;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(25, 15, 0, 0);
    applyStimulus(20, 20, 0, 0);
    applyStimulus(10, 15, 0, 0);

    // Empty the HI tube, then pay 17 from MID/LO only.
    applyStimulus(20, 10, 1, 0);
    repeat (19) applyStimulus(20, 10, 0, 0);
    applyStimulus(30, 13, 0, 0);

    // Empty the LO tube, then 8 owed: one MID, then shortfall of 3.
    applyStimulus(4, 0, 1, 0);
    repeat (4) applyStimulus(4, 0, 0, 0);
    applyStimulus(28, 20, 0, 0);

    repeat (40)
      applyStimulus($urandom_range(0, 31), $urandom_range(0, 31), ($urandom_range(0, 5) == 0), 0);

    // Reset while a coin request is outstanding.
    @(negedge clk);
    start = 1'b1;
    current_amount = 5'd31;
    product_price = 5'd1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (coin_req) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("req_before_reset", 32'(seen), 1);
    #2 reset_n = 1'b0;
    #1;
    invHi = 20; invMid = 20; invLo = 20;
    checkResetState("midreq_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef COIN_TIMEOUT_EN
    applyStimulus(31, 1, 1, 1);
    applyStimulus(31, 1, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
